interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Round-robin interrupt controller on the requester side of the CSR-file interrupt interface.
- Consumes the mask from the CSR file (mie) and the external device request lines. Selects one pending enabled source.
- Raises a one-cycle interrupt strobe with a cause word to the CSR file and core. Holds until the core signals handler completion (mret), then returns a one-cycle acknowledge to the serviced device.

Parameters:
- N_SRC, 32, number of interrupt sources; legal range 2..32. Only mie_i[N_SRC-1:0] is used.
- IDX_W, $clog2(N_SRC), derived width of the scan index.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- int_req_i  input  N_SRC  level requests from devices; held high until acked
- mie_i  input  32  interrupt enable mask from CSR file
- int_rst_i  input  1  handler-complete pulse from core (mret)
- ic_int_o  output  1  one-cycle interrupt strobe to CSR file/core
- mcause_o  output  32  cause of the current/last interrupt
- int_ack_o  output  N_SRC  one-hot, one-cycle acknowledge to the serviced device
- busy_o  output  1  high from RAISE through ACK inclusive

Behaviour:
- Reset (rstn=0 at posedge):
  - state=SCAN, cnt=0.
  - mcause_o=0, ic_int_o=0, int_ack_o=0, busy_o=0.
  - Reset has priority in every state, including mid-service. No ack is issued for an aborted service.
- Outputs are decoded only from registered state: ic_int_o=(state==RAISE), int_ack_o=(state==ACK) ? (1<<cnt) : 0.
- hit = int_req_i[cnt] & mie_i[cnt].
- SCAN:
  - If hit: next state RAISE; latch mcause_o={1'b1, zeros, cnt} (e.g. idx 5 -> 0x8000_0005).
  - Otherwise: cnt <= (cnt==N_SRC-1) ? 0 : cnt+1; stay in SCAN.
- RAISE: lasts exactly 1 cycle; ic_int_o=1; unconditionally goes to BUSY.
- BUSY:
  - cnt frozen; mcause_o stable.
  - Waits for int_rst_i=1, then goes to ACK.
  - Changes to int_req_i or mie_i during BUSY are ignored. A dropped request is still acked. A masked-off source is still completed.
- ACK: lasts exactly 1 cycle; int_ack_o=1<<cnt. Next state SCAN with cnt advanced by 1 (wrapping), so the serviced source gets lowest priority next.
- int_rst_i is ignored in SCAN, RAISE and ACK.
  - If int_rst_i=1 on the same edge RAISE->BUSY, it is not consumed; BUSY needs a new int_rst_i.
- Latency:
  - Request at index cnt: ic_int_o rises 1 cycle after the SCAN edge that sees the hit.
  - Worst case from request assertion to ic_int_o: N_SRC cycles.
- mcause_o holds its value after ACK until the next hit latch.
- No nested interrupts: ic_int_o cannot re-assert before ACK completes.
- Minimum service turnaround is 4 cycles: SCAN-hit, RAISE, BUSY with int_rst_i, ACK.

Test Plan:
- Reset:
  - Stimulus: hold rstn=0 for 3 cycles with int_req_i=all ones, mie_i=all ones.
  - Required: ic_int_o=0, int_ack_o=0, mcause_o=0, busy_o=0 throughout. First strobe after release has mcause_o=0x8000_0000.
- Single source:
  - Stimulus: mie_i=0x20, int_req_i[5]=1; int_rst_i pulsed 10 cycles after ic_int_o.
  - Required: exactly one ic_int_o pulse with mcause_o=0x8000_0005. int_ack_o=0x20 for 1 cycle, one cycle after int_rst_i. The strobe recurs only if the request is held.
- Masking:
  - Stimulus: int_req_i[3]=1, mie_i=0 for 100 cycles, then mie_i=0x8.
  - Required: no strobe while masked. ic_int_o within 32 cycles of unmask, mcause_o=0x8000_0003.
- Fairness:
  - Stimulus: int_req_i[2] and int_req_i[7] held high, mie_i=0x84; bench answers each strobe with int_rst_i after 3 cycles.
  - Required: serviced causes alternate 0x8000_0002 and 0x8000_0007 for ≥6 services.
- Wrap and ignored handshake:
  - Stimulus: only int_req_i[0] asserted while cnt=1; pulse int_rst_i during SCAN.
  - Required: no effect from int_rst_i in SCAN. Service occurs after cnt wraps 31->0, mcause_o=0x8000_0000.
- Abort and drop:
  - Stimulus (a): drop int_req_i during BUSY, then pulse int_rst_i. Required: int_ack_o is still issued.
  - Stimulus (b): assert rstn=0 during BUSY. Required: no int_ack_o, state returns to SCAN with cnt=0.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller, the CSR file/core and the devices.
// The controller is the slave side; the bench or the surrounding SoC drives it as master.
interface interrupt_controller_if #(
  parameter int N_SRC = 32
);
  logic [N_SRC-1:0] int_req_i;
  logic [31:0]      mie_i;
  logic             int_rst_i;
  logic             ic_int_o;
  logic [31:0]      mcause_o;
  logic [N_SRC-1:0] int_ack_o;
  logic             busy_o;

  modport master (
    output int_req_i, mie_i, int_rst_i,
    input  ic_int_o, mcause_o, int_ack_o, busy_o
  );

  modport slave (
    input  int_req_i, mie_i, int_rst_i,
    output ic_int_o, mcause_o, int_ack_o, busy_o
  );
endinterface

// File: rtl/interrupt_controller.sv
// Round-robin interrupt controller: scans one source per cycle, raises a strobe with a cause,
// waits for the handler-complete pulse, then acknowledges the serviced device.
module interrupt_controller #(
  parameter int N_SRC = 32
) (
  input logic             clk,
  input logic             rstn,
  interrupt_controller_if.slave bus
);
  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [1:0] {SCAN, RAISE, BUSY, ACK} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] cnt_reg;
  logic [IDX_W-1:0] cnt_next;
  logic [31:0]      mcause_reg;
  logic             ic_int_reg;
  logic [N_SRC-1:0] ack_reg;
  logic             busy_reg;
  logic [N_SRC-1:0] pending;
  logic             hit;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
      assign pending[gi] = bus.int_req_i[gi] & bus.mie_i[gi];
    end
  endgenerate

  assign hit      = pending[cnt_reg];
  assign cnt_next = (cnt_reg == IDX_W'(N_SRC - 1)) ? '0 : cnt_reg + 1'b1;

  // Outputs are registered alongside the state so they follow it without decode glitches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg  <= SCAN;
      cnt_reg    <= '0;
      mcause_reg <= '0;
      ic_int_reg <= 1'b0;
      ack_reg    <= '0;
      busy_reg   <= 1'b0;
    end else begin
      ic_int_reg <= 1'b0;
      ack_reg    <= '0;
      case (state_reg)
        SCAN: begin
          if (hit) begin
            state_reg  <= RAISE;
            mcause_reg <= {1'b1, {(31 - IDX_W){1'b0}}, cnt_reg};
            ic_int_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        // A completion pulse coinciding with this edge is deliberately not consumed.
        RAISE: state_reg <= BUSY;
        BUSY: begin
          if (bus.int_rst_i) begin
            state_reg <= ACK;
            ack_reg   <= {{(N_SRC - 1){1'b0}}, 1'b1} << cnt_reg;
          end
        end
        ACK: begin
          state_reg <= SCAN;
          cnt_reg   <= cnt_next;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign bus.ic_int_o  = ic_int_reg;
  assign bus.mcause_o  = mcause_reg;
  assign bus.int_ack_o = ack_reg;
  assign bus.busy_o    = busy_reg;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs change and outputs are sampled on the falling edge.
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc;
  int   strobes;

  interrupt_controller_if #(.N_SRC(32)) bus ();

  interrupt_controller #(.N_SRC(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Returns at the falling edge where the strobe is seen, or after max_cyc edges.
  task automatic wait_strobe(input string tag, input int max_cyc, output int cycles);
    cycles = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.ic_int_o) break;
    end
    check({tag, "_strobe"}, {31'd0, bus.ic_int_o}, 32'd1);
  endtask

  // Called at the strobe edge: waits dly edges, pulses completion, checks the ack edge.
  task automatic service(input string tag, input int dly, input logic [31:0] exp_ack);
    repeat (dly) @(negedge clk);
    bus.int_rst_i = 1'b1;
    @(negedge clk);
    bus.int_rst_i = 1'b0;
    check({tag, "_ack"}, bus.int_ack_o, exp_ack);
    @(negedge clk);
    check({tag, "_ack_end"}, {bus.int_ack_o[30:0], bus.busy_o}, 32'd0);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.int_req_i = '1;
    bus.mie_i     = '1;
    bus.int_rst_i = 1'b0;

    // Reset held for three edges with everything requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_int", {31'd0, bus.ic_int_o}, 32'd0);
      check("rst_ack", bus.int_ack_o, 32'd0);
      check("rst_cause", bus.mcause_o, 32'd0);
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("first_int", {31'd0, bus.ic_int_o}, 32'd1);
    check("first_cause", bus.mcause_o, 32'h8000_0000);
    check("first_busy", {31'd0, bus.busy_o}, 32'd1);
    // Completion on the RAISE->BUSY edge must not be taken.
    bus.int_rst_i = 1'b1;
    @(negedge clk);
    bus.int_rst_i = 1'b0;
    check("raise_rst_int", {31'd0, bus.ic_int_o}, 32'd0);
    @(negedge clk);
    check("raise_rst_ack", bus.int_ack_o, 32'd0);
    check("raise_rst_busy", {31'd0, bus.busy_o}, 32'd1);
    service("first", 0, 32'h0000_0001);
    bus.int_req_i = '0;
    bus.mie_i     = '0;

    // Single source at index 5.
    bus.mie_i     = 32'h20;
    bus.int_req_i = 32'h20;
    wait_strobe("single", 40, cyc);
    check("single_cause", bus.mcause_o, 32'h8000_0005);
    strobes = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.ic_int_o) strobes++;
      if (bus.int_ack_o != 0) strobes++;
    end
    check("single_quiet", strobes, 32'd0);
    service("single", 1, 32'h20);
    bus.int_req_i = '0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ic_int_o) strobes++;
    end
    check("single_no_rep", strobes, 32'd0);

    // Masked source must stay silent until enabled.
    bus.int_req_i = 32'h08;
    bus.mie_i     = 32'h0;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ic_int_o) strobes++;
    end
    check("mask_quiet", strobes, 32'd0);
    bus.mie_i = 32'h08;
    wait_strobe("unmask", 32, cyc);
    check("unmask_cause", bus.mcause_o, 32'h8000_0003);
    service("unmask", 1, 32'h08);
    bus.int_req_i = '0;

    // Two held sources alternate; scan resumes at 4 so 7 goes first.
    bus.int_req_i = 32'h84;
    bus.mie_i     = 32'h84;
    for (int k = 0; k < 6; k++) begin
      wait_strobe("fair", 40, cyc);
      check("fair_cause", bus.mcause_o, (k % 2 == 0) ? 32'h8000_0007 : 32'h8000_0002);
      service("fair", 3, (k % 2 == 0) ? 32'h80 : 32'h04);
    end
    bus.int_req_i = '0;

    // Wrap: cnt forced to 0 by reset, advanced to 1, then only source 0 requests.
    @(negedge clk);
    rstn = 1'b0;
    bus.mie_i = '1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.int_req_i = 32'h1;
    bus.int_rst_i = 1'b1;
    @(negedge clk);
    bus.int_rst_i = 1'b0;
    check("wrap_scan_int", {31'd0, bus.ic_int_o}, 32'd0);
    check("wrap_scan_busy", {31'd0, bus.busy_o}, 32'd0);
    wait_strobe("wrap", 40, cyc);
    check("wrap_cycles", cyc, 32'd31);
    check("wrap_cause", bus.mcause_o, 32'h8000_0000);
    service("wrap", 1, 32'h1);
    bus.int_req_i = '0;

    // Request and enable dropped mid-service: the ack is still issued.
    bus.int_req_i = 32'h10;
    bus.mie_i     = 32'h10;
    wait_strobe("drop", 40, cyc);
    check("drop_cause", bus.mcause_o, 32'h8000_0004);
    @(negedge clk);
    bus.int_req_i = '0;
    bus.mie_i     = '0;
    service("drop", 2, 32'h10);
    check("drop_cause_hold", bus.mcause_o, 32'h8000_0004);

    // Reset during BUSY: no ack, scan restarts from 0.
    bus.int_req_i = 32'h40;
    bus.mie_i     = 32'h40;
    wait_strobe("abort", 40, cyc);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_ack", bus.int_ack_o, 32'd0);
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check("abort_cause", bus.mcause_o, 32'd0);
    wait_strobe("abort_re", 40, cyc);
    check("abort_re_cycles", cyc, 32'd7);
    check("abort_re_cause", bus.mcause_o, 32'h8000_0006);
    service("abort_re", 1, 32'h40);
    bus.int_req_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
